sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single-port SRAM between the core's control path (CPU port) and the DMA copy engine (DMA port).
- The CPU port has fixed priority.
- The DMA can lock the SRAM across a read/write pair, bounded in length.
- Read data returns one cycle after grant, steered to the owning requester.
- Sits between the CTL block and the SRAM, replacing ad-hoc shared driving of sram_ADDR/DI/EN/WE.

Parameters:
ADDR_W, 16, SRAM address width
DATA_W, 32, SRAM data width
LOCK_MAX, 4, max consecutive cycles DMA may hold lock while CPU is requesting
STARVE_LIMIT, 8, consecutive DMA-denied cycles before forced DMA grant (feature only)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU access request, held until cpu_gnt
cpu_we  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU address
cpu_di  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access issued this cycle
cpu_rvalid  out  1  cpu_rdata valid
cpu_rdata  out  DATA_W  CPU read data
dma_req  in  1  DMA request, held until dma_gnt
dma_we  in  1  1=write, 0=read
dma_addr  in  ADDR_W  DMA address
dma_di  in  DATA_W  DMA write data
dma_lock  in  1  keep SRAM owned by DMA after this grant
dma_gnt  out  1  DMA access issued this cycle
dma_rvalid  out  1  dma_rdata valid
dma_rdata  out  DATA_W  DMA read data
sram_ADDR  out  ADDR_W  to SRAM
sram_DI  out  DATA_W  to SRAM
sram_EN  out  1  to SRAM
sram_WE  out  1  to SRAM
sram_DO  in  DATA_W  SRAM read data, valid one cycle after EN&!WE

Behaviour:
- Reset (reset=0, async): state=ARB_IDLE, lock_cnt=0, all registered outputs 0; gnt/EN/WE forced 0 while reset is low.
- Grants are combinational from req and state. At most one of cpu_gnt/dma_gnt is high.
- sram_* mirror the granted port's addr/di/we with sram_EN=1. With no grant, sram_EN=0, sram_WE=0, and addr/di hold their last value.
- Read latency 1:
  - A read granted in cycle N gives rvalid=1 at cycle N+1, rdata=sram_DO, to that port only.
  - rdata holds its last value when rvalid=0.
  - Writes produce no rvalid.
- States:
  - ARB_IDLE / ARB_CPU / ARB_DMA: CPU granted if cpu_req, else DMA granted if dma_req. The state records the last owner.
  - DMA granted with dma_lock=1 -> ARB_DMA_LOCK, lock_cnt=0.
  - ARB_DMA_LOCK: only DMA may be granted. lock_cnt increments in each cycle where cpu_req=1.
  - Exit ARB_DMA_LOCK when dma_lock=0 at a DMA grant, or when dma_req=0, or when lock_cnt reaches LOCK_MAX-1 with cpu_req=1. On a LOCK_MAX exit the CPU wins the next cycle even if dma_lock is still 1.
- Simultaneous cpu_req and dma_req in a non-lock state: CPU wins and DMA waits. DMA req must stay stable while waiting; the arbiter does not latch it.
- A request dropped before grant is legal and is ignored.
- Back-to-back grants to the same or different ports are allowed every cycle. rvalid pipeline entries never collide because there is one grant per cycle.
- Reset mid-operation: a pending rvalid is dropped and lock is released.

Optional Feature:
- SRAM_ARB_AGE_EN defined:
  - A counter of consecutive cycles with dma_req=1 and dma_gnt=0.
  - When it reaches STARVE_LIMIT, DMA is granted in the next contended cycle over the CPU, and the counter clears.
  - The counter also clears on any DMA grant.
- Not defined: the counter is absent and the CPU has strict priority outside lock.

Decomposition:
- Shared defines header: ARB_IDLE/ARB_CPU/ARB_DMA/ARB_DMA_LOCK state encodings (2-bit) and owner encoding for the rvalid pipe (OWN_NONE/OWN_CPU/OWN_DMA).
- One sub-module is natural: sram_rd_return. It holds the 1-stage owner pipe and rdata/rvalid steering.

Test Plan:
- CPU only: cpu read addr 0x0010, SRAM holds 0xDEADBEEF -> cpu_gnt same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF; dma_rvalid=0.
- Contention: cpu_req and dma_req both high for 3 cycles -> 3 cpu_gnt, dma_gnt=0; DMA granted in the 4th cycle after cpu_req drops.
- Lock pair: DMA read 0x0100 with dma_lock=1, then write 0x0200 (dma_lock=0) while cpu_req=1 -> both DMA grants consecutive; CPU granted in the third cycle.
- Lock bound: dma_lock stuck at 1, dma_req=1, cpu_req=1, LOCK_MAX=4 -> exactly 4 DMA grants, then cpu_gnt.
- Async reset mid-read: reset low between grant and rvalid -> no rvalid, outputs 0 immediately; after release, state=ARB_IDLE.
- SRAM_ARB_AGE_EN, STARVE_LIMIT=8: continuous cpu_req and dma_req -> dma_gnt on the 9th cycle, then the CPU resumes.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_pkg
//  Description : Shared encodings for the SRAM arbiter. Arbiter state
//                encodings (2-bit) and the owner tags carried by the
//                one-stage read-return pipe.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_arbiter_pkg;

    // Arbiter state; ARB_CPU / ARB_DMA record the last owner.
    localparam logic [1:0] ARB_IDLE     = 2'd0;
    localparam logic [1:0] ARB_CPU      = 2'd1;
    localparam logic [1:0] ARB_DMA      = 2'd2;
    localparam logic [1:0] ARB_DMA_LOCK = 2'd3;

    // Which requester owns the read data coming back next cycle.
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    // Owner tag for a read issued this cycle (at most one grant per cycle).
    function automatic logic [1:0] rd_owner(input logic cpu_rd, input logic dma_rd);
        if (cpu_rd) begin
            return OWN_CPU;
        end
        if (dma_rd) begin
            return OWN_DMA;
        end
        return OWN_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter_if
//  Description : Bundles the CPU port, DMA port and SRAM-side signals of the
//                SRAM arbiter.
//                master : requesters + SRAM (drive req/addr/di/we, sram_DO)
//                slave  : the arbiter (drives gnt/rvalid/rdata, sram_*)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    // CPU port
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_di;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    // DMA port
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_di;
    logic              dma_lock;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    // SRAM side
    logic [ADDR_W-1:0] sram_ADDR;
    logic [DATA_W-1:0] sram_DI;
    logic              sram_EN;
    logic              sram_WE;
    logic [DATA_W-1:0] sram_DO;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_di,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_di, dma_lock,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  sram_ADDR, sram_DI, sram_EN, sram_WE,
        output sram_DO
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_di,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_di, dma_lock,
        output dma_gnt, dma_rvalid, dma_rdata,
        output sram_ADDR, sram_DI, sram_EN, sram_WE,
        input  sram_DO
    );

endinterface
`default_nettype wire

// File: rtl/sram_rd_return.sv
`default_nettype none
// ============================================================================
//  Module      : sram_rd_return
//  Description : One-stage owner pipe for SRAM reads. A read issued in cycle
//                N raises the owner's rvalid in cycle N+1 with rdata taken
//                straight from sram_DO; each rdata holds its last value
//                while its rvalid is low.
//  Ports       : clk, reset (async, active-low)
//                i_cpu_rd / i_dma_rd : read issued this cycle for that port
//                i_sram_do           : SRAM read data
//                o_cpu_rvalid/o_cpu_rdata, o_dma_rvalid/o_dma_rdata
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_rd_return
    import sram_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_cpu_rd,
    input  wire logic              i_dma_rd,
    input  wire logic [DATA_W-1:0] i_sram_do,
    output logic                   o_cpu_rvalid,
    output logic [DATA_W-1:0]      o_cpu_rdata,
    output logic                   o_dma_rvalid,
    output logic [DATA_W-1:0]      o_dma_rdata
);

    logic [1:0]        r_owner;
    logic [DATA_W-1:0] r_cpu_hold;
    logic [DATA_W-1:0] r_dma_hold;
    logic              w_cpu_valid;
    logic              w_dma_valid;

    assign w_cpu_valid = (r_owner == OWN_CPU);
    assign w_dma_valid = (r_owner == OWN_DMA);

    // Reset drops any read in flight, so no rvalid follows a reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner    <= OWN_NONE;
            r_cpu_hold <= '0;
            r_dma_hold <= '0;
        end else begin
            r_owner <= rd_owner(i_cpu_rd, i_dma_rd);
            if (w_cpu_valid) begin
                r_cpu_hold <= i_sram_do;
            end
            if (w_dma_valid) begin
                r_dma_hold <= i_sram_do;
            end
        end
    end

    assign o_cpu_rvalid = w_cpu_valid;
    assign o_dma_rvalid = w_dma_valid;
    assign o_cpu_rdata  = w_cpu_valid ? i_sram_do : r_cpu_hold;
    assign o_dma_rdata  = w_dma_valid ? i_sram_do : r_dma_hold;

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Shares a single-port SRAM between the CPU port (fixed
//                priority) and the DMA copy engine. The DMA may lock the
//                SRAM across consecutive accesses; the lock is broken after
//                LOCK_MAX cycles of CPU waiting. Grants are combinational;
//                read data returns one cycle after grant to its owner.
//  Ports       : clk, reset (async, active-low)
//                bus (sram_arbiter_if.slave): CPU port, DMA port, SRAM side
//  Options     : SRAM_ARB_AGE_EN - DMA starvation counter; after
//                STARVE_LIMIT consecutive denied cycles the DMA wins the
//                next contended cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int LOCK_MAX     = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  wire logic     clk,
    input  wire logic     reset,
    sram_arbiter_if.slave bus
);

    localparam int c_LOCK_W = $clog2(LOCK_MAX + 1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCK_MAX - 1);

    logic [1:0]          r_state;
    logic [c_LOCK_W-1:0] r_lock_cnt;
    logic [ADDR_W-1:0]   r_addr_hold;
    logic [DATA_W-1:0]   r_di_hold;
    logic                w_in_lock;
    logic                w_age_force;
    logic                w_cpu_gnt;
    logic                w_dma_gnt;

    assign w_in_lock = (r_state == ARB_DMA_LOCK);

`ifdef SRAM_ARB_AGE_EN
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    logic [c_STARVE_W-1:0] r_starve;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve <= '0;
        end else if (w_dma_gnt) begin
            r_starve <= '0;
        end else if (bus.dma_req && (r_starve != c_STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    assign w_age_force = (r_starve == c_STARVE_MAX);
`else
    assign w_age_force = 1'b0;
`endif

    // Grant decode; nothing is granted while reset is held low.
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_dma_gnt = 1'b0;
        if (reset) begin
            if (w_in_lock) begin
                w_dma_gnt = bus.dma_req;
            end else if (bus.dma_req && (w_age_force || !bus.cpu_req)) begin
                w_dma_gnt = 1'b1;
            end else begin
                w_cpu_gnt = bus.cpu_req;
            end
        end
    end

    // Arbiter state. Leaving the lock always lands in ARB_DMA, where the
    // CPU (if requesting) wins the next cycle regardless of dma_lock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ARB_IDLE;
            r_lock_cnt <= '0;
        end else if (w_in_lock) begin
            if (bus.cpu_req) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
            // While locked a DMA request is always granted, so !dma_lock
            // here means "lock released at this grant".
            if (!bus.dma_req || !bus.dma_lock ||
                (bus.cpu_req && (r_lock_cnt == c_LOCK_LAST))) begin
                r_state <= ARB_DMA;
            end
        end else if (w_dma_gnt) begin
            r_state    <= bus.dma_lock ? ARB_DMA_LOCK : ARB_DMA;
            r_lock_cnt <= '0;
        end else if (w_cpu_gnt) begin
            r_state <= ARB_CPU;
        end
    end

    // Address / write data hold their last granted value when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr_hold <= '0;
            r_di_hold   <= '0;
        end else if (w_cpu_gnt) begin
            r_addr_hold <= bus.cpu_addr;
            r_di_hold   <= bus.cpu_di;
        end else if (w_dma_gnt) begin
            r_addr_hold <= bus.dma_addr;
            r_di_hold   <= bus.dma_di;
        end
    end

    assign bus.cpu_gnt   = w_cpu_gnt;
    assign bus.dma_gnt   = w_dma_gnt;
    assign bus.sram_EN   = w_cpu_gnt | w_dma_gnt;
    assign bus.sram_WE   = (w_cpu_gnt & bus.cpu_we) | (w_dma_gnt & bus.dma_we);
    assign bus.sram_ADDR = w_cpu_gnt ? bus.cpu_addr :
                           w_dma_gnt ? bus.dma_addr : r_addr_hold;
    assign bus.sram_DI   = w_cpu_gnt ? bus.cpu_di :
                           w_dma_gnt ? bus.dma_di : r_di_hold;

    sram_rd_return #(
        .DATA_W (DATA_W)
    ) u_rd_return (
        .clk          (clk),
        .reset        (reset),
        .i_cpu_rd     (w_cpu_gnt & ~bus.cpu_we),
        .i_dma_rd     (w_dma_gnt & ~bus.dma_we),
        .i_sram_do    (bus.sram_DO),
        .o_cpu_rvalid (bus.cpu_rvalid),
        .o_cpu_rdata  (bus.cpu_rdata),
        .o_dma_rvalid (bus.dma_rvalid),
        .o_dma_rdata  (bus.dma_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Self-checking bench for sram_arbiter. Directed scenarios
//                followed by a randomized phase, all compared each cycle
//                against a behavioural model of the arbitration rules and a
//                reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 32;
    localparam int LOCK_MAX     = 4;
    localparam int STARVE_LIMIT = 8;
`ifdef SRAM_ARB_AGE_EN
    localparam bit AGE = 1'b1;
`else
    localparam bit AGE = 1'b0;
`endif

    logic clk;
    logic reset;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .LOCK_MAX     (LOCK_MAX),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- SRAM model (environment) ----------------
    logic [DATA_W-1:0] sram_mem [0:65535];

    always @(posedge clk) begin
        if (bus.sram_EN) begin
            if (bus.sram_WE) sram_mem[bus.sram_ADDR] <= bus.sram_DI;
            else             bus.sram_DO <= sram_mem[bus.sram_ADDR];
        end
    end

    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
        return {a, ~a};
    endfunction

    // ---------------- Reference model ----------------
    logic [DATA_W-1:0] ref_mem [int];
    bit                m_locked;
    int                m_cpu_waited;   // CPU request cycles spent under the current lock
    int                m_starve;       // consecutive denied DMA request cycles
    logic [ADDR_W-1:0] m_addr_hold;
    logic [DATA_W-1:0] m_di_hold;
    int                m_pend;         // 0 none, 1 CPU read, 2 DMA read returning next
    logic [DATA_W-1:0] m_pend_data;
    logic [DATA_W-1:0] m_cpu_hold;
    logic [DATA_W-1:0] m_dma_hold;
    bit                m_cpu_gnt;
    bit                m_dma_gnt;
    logic              obs_cpu_gnt;
    logic              obs_dma_gnt;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    task automatic model_reset();
        m_locked = 0; m_cpu_waited = 0; m_starve = 0;
        m_addr_hold = '0; m_di_hold = '0;
        m_pend = 0; m_pend_data = '0;
        m_cpu_hold = '0; m_dma_hold = '0;
        m_cpu_gnt = 0; m_dma_gnt = 0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle: predict, compare, then advance the model over the coming edge.
    task automatic tick_check();
        bit e_cpu, e_dma, e_we;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_di;
        @(negedge clk);
        obs_cpu_gnt = bus.cpu_gnt;
        obs_dma_gnt = bus.dma_gnt;
        e_cpu = 0; e_dma = 0;
        if (reset) begin
            if (m_locked) e_dma = bus.dma_req;
            else if (bus.dma_req && (!bus.cpu_req || (AGE && m_starve >= STARVE_LIMIT))) e_dma = 1;
            else e_cpu = bus.cpu_req;
        end
        e_addr = e_cpu ? bus.cpu_addr : (e_dma ? bus.dma_addr : m_addr_hold);
        e_di   = e_cpu ? bus.cpu_di   : (e_dma ? bus.dma_di   : m_di_hold);
        e_we   = (e_cpu && bus.cpu_we) || (e_dma && bus.dma_we);
        check("cpu_gnt",    bus.cpu_gnt,    e_cpu);
        check("dma_gnt",    bus.dma_gnt,    e_dma);
        check("sram_EN",    bus.sram_EN,    e_cpu | e_dma);
        check("sram_WE",    bus.sram_WE,    e_we);
        check("sram_ADDR",  bus.sram_ADDR,  e_addr);
        check("sram_DI",    bus.sram_DI,    e_di);
        check("cpu_rvalid", bus.cpu_rvalid, m_pend == 1);
        check("dma_rvalid", bus.dma_rvalid, m_pend == 2);
        check("cpu_rdata",  bus.cpu_rdata,  (m_pend == 1) ? m_pend_data : m_cpu_hold);
        check("dma_rdata",  bus.dma_rdata,  (m_pend == 2) ? m_pend_data : m_dma_hold);
        m_cpu_gnt = e_cpu;
        m_dma_gnt = e_dma;
        if (reset) begin
            if (m_pend == 1) m_cpu_hold = m_pend_data;
            if (m_pend == 2) m_dma_hold = m_pend_data;
            m_pend = 0;
            if (e_cpu && !bus.cpu_we) begin m_pend = 1; m_pend_data = ref_read(bus.cpu_addr); end
            if (e_dma && !bus.dma_we) begin m_pend = 2; m_pend_data = ref_read(bus.dma_addr); end
            if (e_cpu && bus.cpu_we) ref_mem[int'(bus.cpu_addr)] = bus.cpu_di;
            if (e_dma && bus.dma_we) ref_mem[int'(bus.dma_addr)] = bus.dma_di;
            if (e_cpu || e_dma) begin m_addr_hold = e_addr; m_di_hold = e_di; end
            if (m_locked) begin
                if (bus.cpu_req) m_cpu_waited++;
                if (!bus.dma_req || !bus.dma_lock || m_cpu_waited >= LOCK_MAX) m_locked = 0;
            end else if (e_dma && bus.dma_lock) begin
                m_locked = 1;
                m_cpu_waited = 0;
            end
            if (e_dma) m_starve = 0;
            else if (bus.dma_req) m_starve++;
        end
    endtask

    task automatic tick_adv();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        tick_check();
        tick_adv();
    endtask

    task automatic cpu_drive(input logic req, input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_di = d;
    endtask

    task automatic dma_drive(input logic req, input logic we, input logic lock, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.dma_req = req; bus.dma_we = we; bus.dma_lock = lock; bus.dma_addr = a; bus.dma_di = d;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_cpu, n_dma, first_dma;
        for (int i = 0; i < 65536; i++) sram_mem[i] = init_val(16'(i));
        sram_mem[16'h0010] = 32'hDEADBEEF;
        ref_mem[16'h0010]  = 32'hDEADBEEF;
        bus.sram_DO = '0;
        cpu_drive(0, 0, '0, '0);
        dma_drive(0, 0, 0, '0, '0);
        reset = 1'b0;
        model_reset();

        // Reset state, requests asserted to show grants are suppressed.
        #1;
        cpu_drive(1, 0, 16'h0004, '0);
        tick();
        tick();
        cpu_drive(0, 0, '0, '0);
        reset = 1'b1;
        tick();

        // CPU-only read.
        cpu_drive(1, 0, 16'h0010, '0);
        tick();
        check("cpu_rd_gnt", obs_cpu_gnt, 1'b1);
        cpu_drive(0, 0, '0, '0);
        check("cpu_rd_rvalid", bus.cpu_rvalid, 1'b1);
        check("cpu_rd_rdata",  bus.cpu_rdata, 32'hDEADBEEF);
        check("cpu_rd_dma_rvalid", bus.dma_rvalid, 1'b0);
        tick();

        // Contention for three cycles: CPU wins each, then DMA.
        n_cpu = 0; n_dma = 0;
        dma_drive(1, 0, 0, 16'h0020, '0);
        for (int i = 0; i < 3; i++) begin
            cpu_drive(1, 1, 16'h0030 + 16'(i), 32'h1000 + 32'(i));
            tick();
            n_cpu += int'(obs_cpu_gnt);
            n_dma += int'(obs_dma_gnt);
        end
        check("cont_cpu_cnt", n_cpu, 3);
        check("cont_dma_cnt", n_dma, 0);
        cpu_drive(0, 0, '0, '0);
        tick();
        check("cont_dma_4th", obs_dma_gnt, 1'b1);
        dma_drive(0, 0, 0, '0, '0);
        tick();

        // Locked read/write pair, CPU waiting on the second.
        dma_drive(1, 0, 1, 16'h0100, '0);
        tick();
        check("pair_dma1", obs_dma_gnt, 1'b1);
        dma_drive(1, 1, 0, 16'h0200, 32'hCAFE0001);
        cpu_drive(1, 0, 16'h0200, '0);
        tick();
        check("pair_dma2", obs_dma_gnt, 1'b1);
        dma_drive(0, 0, 0, '0, '0);
        tick();
        check("pair_cpu3", obs_cpu_gnt, 1'b1);
        cpu_drive(0, 0, '0, '0);
        tick();
        check("pair_rdback", bus.cpu_rdata, 32'hCAFE0001);

        // Lock bound: dma_lock stuck high, CPU waiting.
        dma_drive(1, 0, 1, 16'h0040, '0);
        tick();
        cpu_drive(1, 0, 16'h0050, '0);
        n_dma = 0;
        n_cpu = 0;
        for (int i = 0; i < 20 && n_cpu == 0; i++) begin
            tick();
            n_dma += int'(obs_dma_gnt);
            n_cpu += int'(obs_cpu_gnt);
        end
        check("lockmax_dma_cnt", n_dma, LOCK_MAX);
        check("lockmax_cpu_gnt", n_cpu, 1);
        cpu_drive(0, 0, '0, '0);
        dma_drive(0, 0, 0, '0, '0);
        tick();

        // Async reset between a read grant and its return.
        cpu_drive(1, 0, 16'h0010, '0);
        tick_check();
        reset = 1'b0;
        model_reset();
        #1;
        check("rst_now_rvalid", bus.cpu_rvalid, 1'b0);
        check("rst_now_gnt",    bus.cpu_gnt,    1'b0);
        check("rst_now_en",     bus.sram_EN,    1'b0);
        tick_adv();
        check("rst_no_rvalid",  bus.cpu_rvalid, 1'b0);
        tick();
        cpu_drive(0, 0, '0, '0);
        reset = 1'b1;
        tick();

        // Reset while locked releases the lock.
        dma_drive(1, 0, 1, 16'h0060, '0);
        tick_check();
        reset = 1'b0;
        model_reset();
        tick_adv();
        cpu_drive(1, 0, 16'h0070, '0);
        reset = 1'b1;
        tick();
        check("rst_unlock_cpu", obs_cpu_gnt, 1'b1);
        cpu_drive(0, 0, '0, '0);
        dma_drive(0, 0, 0, '0, '0);
        tick();

        // Continuous contention after a fresh reset (starvation ageing).
        reset = 1'b0;
        model_reset();
        tick();
        reset = 1'b1;
        cpu_drive(1, 0, 16'h0080, '0);
        dma_drive(1, 0, 0, 16'h0090, '0);
        first_dma = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (obs_dma_gnt && first_dma == 0) first_dma = i;
            if (i == STARVE_LIMIT + 2) check("age_cpu_resume", obs_cpu_gnt, 1'b1);
        end
        check("age_first_dma", first_dma, AGE ? STARVE_LIMIT + 1 : 0);
        cpu_drive(0, 0, '0, '0);
        dma_drive(0, 0, 0, '0, '0);
        tick();

        // Randomized traffic; requests held until granted.
        for (int i = 0; i < 600; i++) begin
            if (!(bus.cpu_req && !m_cpu_gnt))
                cpu_drive($urandom_range(0, 99) < 55, 1'($urandom_range(0, 1)),
                          16'h0300 + 16'($urandom_range(0, 7)), DATA_W'($urandom));
            if (!(bus.dma_req && !m_dma_gnt))
                dma_drive($urandom_range(0, 99) < 55, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 99) < 35,
                          16'h0300 + 16'($urandom_range(0, 7)), DATA_W'($urandom));
            tick();
        end
        cpu_drive(0, 0, '0, '0);
        dma_drive(0, 0, 0, '0, '0);
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
